// File: rtl/imm_pkg.sv
// ============================================================================
//  Module      : imm_pkg
//  Description : Opcode constants, immediate format enum and decode result
//                type shared by the decode-stage immediate unit.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_LOAD_FP   = 7'b0000111;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_STORE_FP  = 7'b0100111;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_FP     = 7'b1010011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SRX = 3'b101;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6,
        FMT_ZIMM  = 3'd7
    } imm_fmt_e;

    // Immediate is carried at the widest XLEN; narrower stages keep the low bits.
    typedef struct packed {
        logic [63:0] imm;
        imm_fmt_e    fmt;
        logic        illegal;
    } imm_result_t;

    function automatic logic [63:0] sext32_64(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
//  Module      : imm_decode
//  Description : Combinational instruction -> immediate/format/illegal decode.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit FP_EN = 1'b1
) (
    input  logic [31:0] i_instr,
    output imm_result_t o_res
);

    localparam bit IS_RV64 = (XLEN == 64);

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_is_shift;
    logic        w_shift_hi_bad;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opc          = i_instr[6:0];
    assign w_f3           = i_instr[14:12];
    assign w_is_shift     = (w_f3 == F3_SLL) || (w_f3 == F3_SRX);
    // Bit 30 selects arithmetic shift, so it is excluded from the upper-bit check.
    assign w_shift_hi_bad = |{i_instr[31], i_instr[29:26]};

    assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                      i_instr[11:8], 1'b0};
    assign w_imm_u = {i_instr[31:12], 12'd0};
    assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                      i_instr[30:21], 1'b0};

    always_comb begin
        o_res = '{imm: 64'd0, fmt: FMT_NONE, illegal: 1'b0};
        case (w_opc)
            OPC_OP_IMM: begin
                if (w_is_shift) begin
                    if (w_shift_hi_bad || (!IS_RV64 && i_instr[25])) begin
                        o_res.illegal = 1'b1;
                    end else begin
                        o_res.fmt = FMT_SHAMT;
                        o_res.imm = IS_RV64 ? {58'd0, i_instr[25:20]} : {59'd0, i_instr[24:20]};
                    end
                end else begin
                    o_res.fmt = FMT_I;
                    o_res.imm = sext32_64(w_imm_i);
                end
            end
            OPC_OP_IMM_32: begin
                if (!IS_RV64) begin
                    o_res.illegal = 1'b1;
                end else if (w_is_shift) begin
                    if (w_shift_hi_bad || i_instr[25]) begin
                        o_res.illegal = 1'b1;
                    end else begin
                        o_res.fmt = FMT_SHAMT;
                        o_res.imm = {59'd0, i_instr[24:20]};
                    end
                end else begin
                    o_res.fmt = FMT_I;
                    o_res.imm = sext32_64(w_imm_i);
                end
            end
            OPC_LOAD, OPC_JALR, OPC_MISC_MEM: begin
                o_res.fmt = FMT_I;
                o_res.imm = sext32_64(w_imm_i);
            end
            OPC_LOAD_FP: begin
                if (FP_EN) begin
                    o_res.fmt = FMT_I;
                    o_res.imm = sext32_64(w_imm_i);
                end else begin
                    o_res.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                o_res.fmt = FMT_S;
                o_res.imm = sext32_64(w_imm_s);
            end
            OPC_STORE_FP: begin
                if (FP_EN) begin
                    o_res.fmt = FMT_S;
                    o_res.imm = sext32_64(w_imm_s);
                end else begin
                    o_res.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                o_res.fmt = FMT_B;
                o_res.imm = sext32_64(w_imm_b);
            end
            OPC_JAL: begin
                o_res.fmt = FMT_J;
                o_res.imm = sext32_64(w_imm_j);
            end
            OPC_LUI, OPC_AUIPC: begin
                o_res.fmt = FMT_U;
                o_res.imm = sext32_64(w_imm_u);
            end
            OPC_SYSTEM: begin
                case (w_f3)
                    3'b000: begin
                        o_res.fmt = FMT_I;
                        o_res.imm = sext32_64(w_imm_i);
                    end
                    3'b101, 3'b110, 3'b111: begin
                        o_res.fmt = FMT_ZIMM;
                        o_res.imm = {59'd0, i_instr[19:15]};
                    end
                    3'b100:  o_res.illegal = 1'b1;
                    default: ;
                endcase
            end
            OPC_OP: ;
            OPC_OP_32: begin
                if (!IS_RV64) o_res.illegal = 1'b1;
            end
            OPC_OP_FP: begin
                if (!FP_EN) o_res.illegal = 1'b1;
            end
            default: o_res.illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_gen_stage.sv
// ============================================================================
//  Module      : imm_gen_stage
//  Description : Registered immediate-generation stage with valid/ready
//                handshake and a one-deep skid behind the output register.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter bit FP_EN = 1'b1,
    parameter int TAG_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_instr,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_imm,
    output imm_fmt_e         o_fmt,
    output logic             o_illegal,
    output logic [TAG_W-1:0] o_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    imm_result_t w_dec;
    entry_t      w_new;
    entry_t      out_q;
    entry_t      out_d;
    entry_t      skid_q;
    entry_t      skid_d;
    logic        out_valid_q;
    logic        out_valid_d;
    logic        skid_valid_q;
    logic        skid_valid_d;
    logic        w_accept;
    logic        w_consume;

    imm_decode #(
        .XLEN  (XLEN),
        .FP_EN (FP_EN)
    ) u_decode (
        .i_instr (i_instr),
        .o_res   (w_dec)
    );

    assign w_new = '{imm: w_dec.imm[XLEN-1:0], fmt: w_dec.fmt,
                     illegal: w_dec.illegal, tag: i_tag};

    generate
        if (XLEN < 64) begin : g_trim
            logic w_unused_hi;
            assign w_unused_hi = ^w_dec.imm[63:XLEN];
        end
    endgenerate

    assign o_ready   = !skid_valid_q;
    assign w_accept  = i_valid && o_ready;
    assign w_consume = out_valid_q && i_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || w_consume) begin
            if (skid_valid_q) begin
                // Oldest entry advances first; a same-cycle accept refills the skid.
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = w_accept;
                if (w_accept) skid_d = w_new;
            end else if (w_accept) begin
                out_d       = w_new;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            skid_d       = w_new;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_imm     = out_q.imm;
    assign o_fmt     = out_q.fmt;
    assign o_illegal = out_q.illegal;
    assign o_tag     = out_q.tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
// ============================================================================
//  Module      : tb_imm_gen_stage
//  Description : Directed bench for imm_gen_stage (RV32 with FP, RV64 without).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imm_gen_stage;
    import imm_pkg::*;

    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             valid;
    logic             ready;
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;

    logic             rdy32, vld32, ill32;
    logic [31:0]      imm32;
    imm_fmt_e         fmt32;
    logic [TAG_W-1:0] tag32;
    logic             rdy64, vld64, ill64;
    logic [63:0]      imm64;
    imm_fmt_e         fmt64;
    logic [TAG_W-1:0] tag64;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic [TAG_W-1:0] q[$];

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(32), .FP_EN(1'b1), .TAG_W(TAG_W)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy32),
        .i_instr(instr), .i_tag(tag), .o_valid(vld32), .i_ready(ready),
        .o_imm(imm32), .o_fmt(fmt32), .o_illegal(ill32), .o_tag(tag32)
    );

    imm_gen_stage #(.XLEN(64), .FP_EN(1'b0), .TAG_W(TAG_W)) u_dut64 (
        .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(rdy64),
        .i_instr(instr), .i_tag(tag), .o_valid(vld64), .i_ready(ready),
        .o_imm(imm64), .o_fmt(fmt64), .o_illegal(ill64), .o_tag(tag64)
    );

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // One accepted instruction, checked on both configurations one edge later.
    task automatic vec(input string name, input logic [31:0] ins,
                       input logic [63:0] e32, input logic [2:0] f32, input logic l32,
                       input logic [63:0] e64, input logic [2:0] f64, input logic l64);
        instr = ins;
        valid = 1'b1;
        tag   = tag + 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        check_eq({name, ".v32"},   vld32, 1);
        check_eq({name, ".imm32"}, imm32, e32);
        check_eq({name, ".fmt32"}, fmt32, f32);
        check_eq({name, ".ill32"}, ill32, l32);
        check_eq({name, ".imm64"}, imm64, e64);
        check_eq({name, ".fmt64"}, fmt64, f64);
        check_eq({name, ".ill64"}, ill64, l64);
        check_eq({name, ".tag"},   tag32, tag);
    endtask

    // Advance one cycle, scoring handshakes at the negedge against the tag queue.
    task automatic tick();
        logic [TAG_W-1:0] exp_tag;
        @(negedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (vld32 && ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check_eq("tag_unexpected", vld32, 0);
                end else begin
                    exp_tag = q.pop_front();
                    check_eq("order32", tag32, exp_tag);
                    check_eq("order64", tag64, exp_tag);
                end
            end
            if (valid && rdy32) q.push_back(tag);
        end
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] t);
        logic acc;
        int   guard;
        tag   = t;
        valid = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 20) begin
            acc = rdy32;
            tick();
            guard++;
        end
        if (!acc) check_eq("send_timeout", acc, 1);
    endtask

    task automatic drain();
        int guard;
        valid = 1'b0;
        ready = 1'b1;
        guard = 0;
        while ((vld32 || q.size() != 0) && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("drain_done", vld32, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]      rpat;
        logic [15:0]      vpat;
        logic [TAG_W-1:0] tg;
        logic             acc;

        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b1; instr = 32'd0; tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_valid", vld32, 0);
        check_eq("rst_ready", rdy32, 1);
        check_eq("rst_imm32", imm32, 0);
        check_eq("rst_imm64", imm64, 0);
        check_eq("rst_fmt",   fmt32, FMT_NONE);
        check_eq("rst_ill",   ill32, 0);
        check_eq("rst_tag",   tag32, 0);

        vec("addi",    32'hFFF00093, 64'hFFFFFFFF, FMT_I, 0, 64'hFFFFFFFFFFFFFFFF, FMT_I, 0);
        vec("beq",     32'hFE000EE3, 64'hFFFFFFFC, FMT_B, 0, 64'hFFFFFFFFFFFFFFFC, FMT_B, 0);
        vec("lui",     32'h800000B7, 64'h80000000, FMT_U, 0, 64'hFFFFFFFF80000000, FMT_U, 0);
        vec("srai63",  32'h43F0D093, 64'h0, FMT_NONE, 1, 64'h3F, FMT_SHAMT, 0);
        vec("srai5",   32'h4050D093, 64'h5, FMT_SHAMT, 0, 64'h5, FMT_SHAMT, 0);
        vec("csrrwi",  32'h300FD073, 64'h1F, FMT_ZIMM, 0, 64'h1F, FMT_ZIMM, 0);
        vec("badopc",  32'h0000707B, 64'h0, FMT_NONE, 1, 64'h0, FMT_NONE, 1);
        vec("sw",      32'hFE20AC23, 64'hFFFFFFF8, FMT_S, 0, 64'hFFFFFFFFFFFFFFF8, FMT_S, 0);
        vec("jal",     32'h001000EF, 64'h800, FMT_J, 0, 64'h800, FMT_J, 0);
        vec("flw",     32'h00412087, 64'h4, FMT_I, 0, 64'h0, FMT_NONE, 1);
        vec("addiw",   32'hFFF0809B, 64'h0, FMT_NONE, 1, 64'hFFFFFFFFFFFFFFFF, FMT_I, 0);
        vec("slliw",   32'h01F0909B, 64'h0, FMT_NONE, 1, 64'h1F, FMT_SHAMT, 0);
        vec("slliw25", 32'h03F0909B, 64'h0, FMT_NONE, 1, 64'h0, FMT_NONE, 1);
        vec("slli",    32'h00509093, 64'h5, FMT_SHAMT, 0, 64'h5, FMT_SHAMT, 0);
        vec("slli_hi", 32'h04509093, 64'h0, FMT_NONE, 1, 64'h0, FMT_NONE, 1);
        vec("csrrs",   32'h30002073, 64'h0, FMT_NONE, 0, 64'h0, FMT_NONE, 0);
        vec("sys100",  32'h30004073, 64'h0, FMT_NONE, 1, 64'h0, FMT_NONE, 1);
        vec("add",     32'h002081B3, 64'h0, FMT_NONE, 0, 64'h0, FMT_NONE, 0);
        vec("fadd",    32'h00000053, 64'h0, FMT_NONE, 0, 64'h0, FMT_NONE, 1);
        vec("auipc",   32'h12345097, 64'h12345000, FMT_U, 0, 64'h12345000, FMT_U, 0);
        @(posedge clk); #1;
        check_eq("idle_valid", vld32, 0);

        // Back-pressure: four tags with the consumer stalled for three cycles.
        n_out = 0;
        ready = 1'b0;
        send(8'd1);
        send(8'd2);
        tag = 8'd3;
        check_eq("ready_drop", rdy32, 0);
        check_eq("hold_tag_a", tag32, 1);
        tick();
        check_eq("hold_tag_b", tag32, 1);
        check_eq("hold_valid", vld32, 1);
        ready = 1'b1;
        send(8'd3);
        send(8'd4);
        drain();
        check_eq("bp_count", n_out, 4);

        // Flush with output and skid both occupied and a new input offered.
        n_out = 0;
        ready = 1'b0;
        send(8'd10);
        send(8'd11);
        check_eq("flush_full", rdy32, 0);
        flush = 1'b1;
        valid = 1'b1;
        tag   = 8'd12;
        tick();
        flush = 1'b0;
        valid = 1'b0;
        check_eq("flush_valid", vld32, 0);
        check_eq("flush_ready", rdy32, 1);
        check_eq("flush_v64",   vld64, 0);
        ready = 1'b1;
        send(8'd13);
        drain();
        check_eq("flush_count", n_out, 1);

        // Mixed valid/ready pattern: every tag must emerge once, in order.
        n_out = 0;
        rpat  = 16'b1011_0010_1110_0100;
        vpat  = 16'b1101_1011_0111_1001;
        tg    = 8'd20;
        valid = 1'b0;
        for (int i = 0; i < 48; i++) begin
            ready = rpat[i % 16];
            if (!valid && vpat[i % 16]) begin
                valid = 1'b1;
                tag   = tg;
            end
            acc = valid && rdy32;
            tick();
            if (acc) begin
                tg    = tg + 1'b1;
                valid = 1'b0;
            end
        end
        drain();
        check_eq("mix_count", n_out, int'(tg) - 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
